// File: rtl/fpu_mul_ctrl_if.sv
// fpu_mul_ctrl_if: operand-request and result handshake bundle for fpu_mul_ctrl.
interface fpu_mul_ctrl_if;
    logic       In_valid;
    logic       In_ready;
    logic [7:0] Ex_ext;
    logic [7:0] Ey_ext;
    logic       Mx_zero;
    logic       My_zero;
    logic       Out_valid;
    logic       Out_ready;
    logic [1:0] Special;
    modport master (
        output In_valid, Ex_ext, Ey_ext, Mx_zero, My_zero, Out_ready,
        input  In_ready, Out_valid, Special
    );
    modport slave (
        input  In_valid, Ex_ext, Ey_ext, Mx_zero, My_zero, Out_ready,
        output In_ready, Out_valid, Special
    );
endinterface

// File: rtl/fpu_mul_ctrl.sv
// fpu_mul_ctrl: FP32 multiplier sequencer (LOAD/MUL/NORM/DONE) with special-operand classification.
// Define FPU_MUL_BYPASS_EN to send special operands straight from LOAD to DONE.
module fpu_mul_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic          CLK,
    input  logic          RST,
    fpu_mul_ctrl_if.slave bus,
    input  logic          Flush,
    output logic          Enable,
    output logic          Mul_en,
    output logic          Norm_en,
    output logic          Busy
);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, NORM, DONE} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       cls, cls_nx, in_cls;
    logic             x_max, y_max, x_zero, y_zero, any_nan;
    always_comb begin
        x_max   = bus.Ex_ext == 8'hFF;
        y_max   = bus.Ey_ext == 8'hFF;
        x_zero  = bus.Ex_ext == 8'h00 && bus.Mx_zero;
        y_zero  = bus.Ey_ext == 8'h00 && bus.My_zero;
        any_nan = (x_max && !bus.Mx_zero) || (y_max && !bus.My_zero) ||
                  (x_max && y_zero) || (y_max && x_zero);
        in_cls  = any_nan ? 2'b11 : (x_max || y_max) ? 2'b10 : (x_zero || y_zero) ? 2'b01 : 2'b00;
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            cls   <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cls   <= cls_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cls_nx   = cls;
        case (state)
            IDLE: if (bus.In_valid) begin
                state_nx = LOAD;
                cls_nx   = in_cls;
            end
            LOAD: begin
                cnt_nx = CNT_W'(MUL_CYCLES - 1);
`ifdef FPU_MUL_BYPASS_EN
                state_nx = (cls != 2'b00) ? DONE : MUL;
`else
                state_nx = MUL;
`endif
            end
            MUL: begin
                state_nx = (cnt == '0) ? NORM : MUL;
                cnt_nx   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
            end
            NORM: state_nx = DONE;
            DONE: state_nx = bus.Out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        // Flush overrides every other transition, including accept and result take.
        if (Flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            cls_nx   = 2'b00;
        end
    end
    assign Enable        = state != LOAD;
    assign Mul_en        = state == MUL;
    assign Norm_en       = state == NORM;
    assign Busy          = state != IDLE;
    assign bus.In_ready  = state == IDLE;
    assign bus.Out_valid = state == DONE;
    assign bus.Special   = cls;
endmodule

// File: tb/tb_fpu_mul_ctrl.sv
// tb_fpu_mul_ctrl: randomized self-checking bench for fpu_mul_ctrl against a classification/timing model.
module tb_fpu_mul_ctrl;
    localparam int MC = 4;
`ifdef FPU_MUL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic CLK = 1'b0;
    logic RST;
    logic Flush, Enable, Mul_en, Norm_en, Busy;
    int checks = 0;
    int errors = 0;
    fpu_mul_ctrl_if bus();
    fpu_mul_ctrl #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .Flush(Flush),
        .Enable(Enable), .Mul_en(Mul_en), .Norm_en(Norm_en), .Busy(Busy)
    );
    always #5 CLK = ~CLK;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    // Per-operand kind: 0 finite, 1 zero, 2 inf, 3 nan; then combine by priority.
    function automatic logic [1:0] classify(input logic [7:0] ex, input logic [7:0] ey, input logic mxz, input logic myz);
        int kx, ky;
        kx = (ex == 255) ? (mxz ? 2 : 3) : ((ex == 0 && mxz) ? 1 : 0);
        ky = (ey == 255) ? (myz ? 2 : 3) : ((ey == 0 && myz) ? 1 : 0);
        if (kx == 3 || ky == 3 || (kx == 2 && ky == 1) || (kx == 1 && ky == 2)) return 2'd3;
        if (kx == 2 || ky == 2) return 2'd2;
        if (kx == 1 || ky == 1) return 2'd1;
        return 2'd0;
    endfunction
    task automatic check_idle(input string tag);
        checks++;
        if (Enable !== 1'b1 || Mul_en !== 1'b0 || Norm_en !== 1'b0 || bus.Out_valid !== 1'b0 ||
            bus.In_ready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: En=%b Mul=%b Norm=%b Ov=%b Ir=%b Busy=%b, required 1 0 0 0 1 0",
                     tag, Enable, Mul_en, Norm_en, bus.Out_valid, bus.In_ready, Busy);
        end
    endtask
    task automatic do_op(input logic [7:0] ex, input logic [7:0] ey, input logic mxz, input logic myz,
                         input int stall, input string tag);
        logic [1:0] ec;
        int lat, nen, nmul, nnorm, elat, emul, enorm, n;
        ec    = classify(ex, ey, mxz, myz);
        emul  = (BYP && ec != 2'b00) ? 0 : MC;
        enorm = (BYP && ec != 2'b00) ? 0 : 1;
        elat  = (BYP && ec != 2'b00) ? 1 : MC + 2;
        bus.Ex_ext = ex; bus.Ey_ext = ey; bus.Mx_zero = mxz; bus.My_zero = myz;
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1;
        n = 0;
        while (!bus.In_ready && n < 50) begin step(); n++; end
        step();
        bus.In_valid = 1'b0;
        bus.Ex_ext = 8'($urandom); bus.Ey_ext = 8'($urandom);
        bus.Mx_zero = 1'($urandom); bus.My_zero = 1'($urandom);
        lat = 0; nen = 0; nmul = 0; nnorm = 0;
        while (!bus.Out_valid && lat < 60) begin
            nen += int'(!Enable); nmul += int'(Mul_en); nnorm += int'(Norm_en);
            checks++;
            if (int'(!Enable) + int'(Mul_en) + int'(Norm_en) > 1) begin
                errors++;
                $display("FAIL %s excl: En=%b Mul=%b Norm=%b, required at most one active", tag, Enable, Mul_en, Norm_en);
            end
            step(); lat++;
        end
        checks++;
        if (lat != elat) begin errors++; $display("FAIL %s latency: got %0d edges, required %0d", tag, lat, elat); end
        checks++;
        if (nen != 1) begin errors++; $display("FAIL %s load: Enable low %0d cycles, required 1", tag, nen); end
        checks++;
        if (nmul != emul) begin errors++; $display("FAIL %s mul: Mul_en %0d cycles, required %0d", tag, nmul, emul); end
        checks++;
        if (nnorm != enorm) begin errors++; $display("FAIL %s norm: Norm_en %0d cycles, required %0d", tag, nnorm, enorm); end
        checks++;
        if (bus.Special !== ec) begin errors++; $display("FAIL %s special: got %b, required %b", tag, bus.Special, ec); end
        for (int i = 0; i < stall; i++) begin
            step();
            checks++;
            if (bus.Out_valid !== 1'b1 || bus.Special !== ec || bus.In_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: Ov=%b Sp=%b Ir=%b, required 1 %b 0", tag, bus.Out_valid, bus.Special, bus.In_ready, ec);
            end
        end
        bus.Out_ready = 1'b1;
        step();
        bus.Out_ready = 1'b0;
        check_idle({tag, " release"});
    endtask
    task automatic test_reset();
        int n;
        check_idle("reset_state");
        checks++;
        if (bus.Special !== 2'b00) begin errors++; $display("FAIL reset_special: got %b, required 00", bus.Special); end
        RST = 1'b1;
        step();
        bus.Ex_ext = 8'h80; bus.Ey_ext = 8'h7F; bus.Mx_zero = 1'b0; bus.My_zero = 1'b0;
        bus.In_valid = 1'b1;
        n = 0;
        while (!bus.In_ready && n < 50) begin step(); n++; end
        step();
        bus.In_valid = 1'b0;
        step();
        step();
        checks++;
        if (Mul_en !== 1'b1) begin errors++; $display("FAIL reset_pre_mul: Mul_en=%b, required 1", Mul_en); end
        RST = 1'b0;
        #1;
        check_idle("reset_async_mid_mul");
        step();
        check_idle("reset_held");
        RST = 1'b1;
        step();
    endtask
    task automatic test_normal();
        do_op(8'h80, 8'h7F, 1'b0, 1'b0, 0, "normal");
    endtask
    task automatic test_backpressure();
        do_op(8'h85, 8'h01, 1'b1, 1'b0, 5, "backpressure");
    endtask
    task automatic test_special();
        do_op(8'hFF, 8'h00, 1'b1, 1'b1, 1, "inf_times_zero");
        do_op(8'hFF, 8'h10, 1'b1, 1'b0, 0, "inf");
        do_op(8'h00, 8'h10, 1'b1, 1'b0, 0, "zero");
        do_op(8'h00, 8'h00, 1'b0, 1'b0, 0, "denormal");
        do_op(8'h10, 8'hFF, 1'b1, 1'b0, 0, "nan_y");
    endtask
    task automatic test_random();
        logic [7:0] ex, ey;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: ex = 8'h00;
                1: ex = 8'hFF;
                2: ex = 8'($urandom_range(1, 254));
                default: ex = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: ey = 8'h00;
                1: ey = 8'hFF;
                2: ey = 8'($urandom_range(1, 254));
                default: ey = 8'($urandom);
            endcase
            do_op(ex, ey, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask
    task automatic test_flush();
        int n;
        bus.Ex_ext = 8'h80; bus.Ey_ext = 8'h7F; bus.Mx_zero = 1'b0; bus.My_zero = 1'b0;
        bus.In_valid = 1'b1;
        n = 0;
        while (!bus.In_ready && n < 50) begin step(); n++; end
        step();
        bus.In_valid = 1'b0;
        step();
        step();
        checks++;
        if (Mul_en !== 1'b1) begin errors++; $display("FAIL flush_pre: Mul_en=%b, required 1", Mul_en); end
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check_idle("flush_mid_mul");
        checks++;
        if (bus.Special !== 2'b00) begin errors++; $display("FAIL flush_special: got %b, required 00", bus.Special); end
        for (int i = 0; i < MC + 3; i++) begin
            step();
            checks++;
            if (Norm_en !== 1'b0 || bus.Out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_after: Norm=%b Ov=%b, required 0 0", Norm_en, bus.Out_valid);
            end
        end
        bus.In_valid = 1'b1;
        Flush = 1'b1;
        step();
        check_idle("flush_blocks_accept");
        bus.In_valid = 1'b0;
        Flush = 1'b0;
        step();
    endtask
    task automatic test_back_to_back();
        int n, span;
        bus.Ex_ext = 8'h90; bus.Ey_ext = 8'h60; bus.Mx_zero = 1'b0; bus.My_zero = 1'b0;
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1;
        n = 0;
        while (!bus.In_ready && n < 50) begin step(); n++; end
        step();
        span = 1;
        while (!bus.Out_valid && span < 60) begin
            checks++;
            if (!Enable && Mul_en) begin errors++; $display("FAIL b2b_overlap: Enable low with Mul_en high"); end
            step(); span++;
        end
        bus.Out_ready = 1'b1;
        step(); span++;
        bus.Out_ready = 1'b0;
        checks++;
        if (bus.In_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: In_ready=%b, required 1", bus.In_ready); end
        step();
        checks++;
        if (Enable !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: Enable=%b Busy=%b, required 0 1", Enable, Busy);
        end
        checks++;
        if (span != MC + 4) begin errors++; $display("FAIL b2b_throughput: got %0d cycles, required %0d", span, MC + 4); end
        bus.In_valid = 1'b0;
        n = 0;
        while (!bus.Out_valid && n < 60) begin step(); n++; end
        bus.Out_ready = 1'b1;
        step();
        bus.Out_ready = 1'b0;
        check_idle("b2b_end");
    endtask
    initial begin
        RST = 1'b0;
        Flush = 1'b0;
        bus.In_valid = 1'b0; bus.Out_ready = 1'b0;
        bus.Ex_ext = 8'h00; bus.Ey_ext = 8'h00; bus.Mx_zero = 1'b0; bus.My_zero = 1'b0;
        step();
        step();
        test_reset();
        test_normal();
        test_backpressure();
        test_special();
        test_random();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
